// File: rtl/shift_round_clip.sv
`default_nettype none
// =============================================================================
// Module   : shift_round_clip
// Brief    : Multi-channel arbiter feeding a round / arithmetic-shift / clip
//            stage, registered into a one-entry output slot with a clip counter.
// Revision : 1.0 - initial release
// =============================================================================
module shift_round_clip #(
    parameter int FLUX      = 2,
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 16,
    parameter int SHIFT_NUM = 11,
    parameter int ROUND     = 1,
    parameter int SIGNED    = 1,
    parameter int ARB_MODE  = 1,
    parameter int TAG_W     = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr_stats,
    input  logic [FLUX-1:0]        rd_empty,
    input  logic [FLUX*DATA_W-1:0] rd_dout,
    output logic [FLUX-1:0]        rd_read,
    input  logic                   wr_full,
    output logic                   wr_write,
    output logic [OUT_W-1:0]       wr_din,
    output logic [TAG_W-1:0]       wr_tag,
    output logic [15:0]            sat_count
);

    // Two guard bits keep the rounding sum from overflowing for any legal shift.
    localparam int c_ext_w = DATA_W + 2;
    localparam logic signed [c_ext_w-1:0] c_round =
        (ROUND != 0 && SHIFT_NUM > 0) ? c_ext_w'(1) << (SHIFT_NUM > 0 ? SHIFT_NUM - 1 : 0) : '0;
    localparam logic signed [c_ext_w-1:0] c_max =
        (SIGNED != 0) ? (c_ext_w'(1) << (OUT_W - 1)) - c_ext_w'(1)
                      : (c_ext_w'(1) << OUT_W) - c_ext_w'(1);
    localparam logic signed [c_ext_w-1:0] c_min =
        (SIGNED != 0) ? c_ext_w'(0) - (c_ext_w'(1) << (OUT_W - 1)) : '0;

    logic                      r_valid;
    logic [OUT_W-1:0]          r_data;
    logic [TAG_W-1:0]          r_tag;
    logic [TAG_W-1:0]          r_last_grant;
    logic [15:0]               r_sat_count;

    logic [TAG_W-1:0]          w_grant;
    logic [TAG_W-1:0]          w_low_any;
    logic [TAG_W-1:0]          w_low_above;
    logic                      w_found_above;
    logic [TAG_W-1:0]          w_high;
    logic                      w_any;
    logic                      w_can_load;
    logic                      w_write;
    logic [FLUX-1:0]           w_onehot;
    logic [DATA_W-1:0]         w_sample;
    logic signed [c_ext_w-1:0] w_ext;
    logic signed [c_ext_w-1:0] w_sum;
    logic signed [c_ext_w-1:0] w_shr;
    logic                      w_hi;
    logic                      w_lo;
    logic                      w_clip;
    logic [OUT_W-1:0]          w_res;

    // Descending scans leave the lowest qualifying index; the round-robin pick
    // prefers the lowest channel above last_grant, else wraps to the lowest.
    always_comb begin
        w_low_any     = '0;
        w_low_above   = '0;
        w_found_above = 1'b0;
        w_high        = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (!rd_empty[i]) begin
                w_low_any = TAG_W'(i);
                if (TAG_W'(i) > r_last_grant) begin
                    w_low_above   = TAG_W'(i);
                    w_found_above = 1'b1;
                end
            end
        end
        for (int i = 0; i < FLUX; i++) begin
            if (!rd_empty[i]) begin
                w_high = TAG_W'(i);
            end
        end
        if (ARB_MODE == 0) begin
            w_grant = w_high;
        end else begin
            w_grant = w_found_above ? w_low_above : w_low_any;
        end
    end

    assign w_any      = ~&rd_empty;
    assign w_write    = r_valid & ~wr_full;
    assign w_can_load = en & (~r_valid | ~wr_full) & w_any;
    assign w_onehot   = FLUX'(1) << w_grant;
    assign rd_read    = (w_can_load && rst_n) ? w_onehot : '0;

    always_comb begin
        w_sample = rd_dout[int'(w_grant) * DATA_W +: DATA_W];
        w_ext    = (SIGNED != 0) ? {{2{w_sample[DATA_W-1]}}, w_sample} : {2'b00, w_sample};
        w_sum    = w_ext + c_round;
        w_shr    = w_sum >>> SHIFT_NUM;
        w_hi     = (w_shr > c_max);
        w_lo     = (w_shr < c_min);
        w_clip   = w_hi | w_lo;
        if (w_hi) begin
            w_res = c_max[OUT_W-1:0];
        end else if (w_lo) begin
            w_res = c_min[OUT_W-1:0];
        end else begin
            w_res = w_shr[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tag        <= '0;
            r_last_grant <= TAG_W'(FLUX - 1);
            r_sat_count  <= '0;
        end else begin
            if (w_can_load) begin
                r_valid <= 1'b1;
                r_data  <= w_res;
                r_tag   <= w_grant;
                if (ARB_MODE != 0) begin
                    r_last_grant <= w_grant;
                end
            end else if (w_write) begin
                r_valid <= 1'b0;
            end
            if (clr_stats) begin
                r_sat_count <= '0;
            end else if (w_can_load && w_clip && r_sat_count != 16'hFFFF) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign wr_write  = w_write;
    assign wr_din    = r_data;
    assign wr_tag    = r_tag;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_round_clip.sv
`default_nettype none
// =============================================================================
// Module   : tb_shift_round_clip
// Brief    : Two shift_round_clip configurations driven in parallel and checked
//            against an arithmetic reference model plus literal expectations.
// Revision : 1.0 - initial release
// =============================================================================
module tb_shift_round_clip;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        clr_stats;
    logic        wr_full;
    logic [1:0]  rd_empty;
    logic [63:0] rd_dout;

    logic [1:0]  rd_read_a, rd_read_b;
    logic        wr_write_a, wr_write_b;
    logic [15:0] wr_din_a;
    logic [7:0]  wr_din_b;
    logic        wr_tag_a, wr_tag_b;
    logic [15:0] sat_a, sat_b;

    int checks   = 0;
    int failures = 0;

    // Instance a: signed 32->16, round-robin. Instance b: unsigned 32->8, fixed priority.
    shift_round_clip #(
        .FLUX(2), .DATA_W(32), .OUT_W(16), .SHIFT_NUM(11),
        .ROUND(1), .SIGNED(1), .ARB_MODE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_stats(clr_stats),
        .rd_empty(rd_empty), .rd_dout(rd_dout), .rd_read(rd_read_a),
        .wr_full(wr_full), .wr_write(wr_write_a), .wr_din(wr_din_a),
        .wr_tag(wr_tag_a), .sat_count(sat_a)
    );

    shift_round_clip #(
        .FLUX(2), .DATA_W(32), .OUT_W(8), .SHIFT_NUM(11),
        .ROUND(1), .SIGNED(0), .ARB_MODE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_stats(clr_stats),
        .rd_empty(rd_empty), .rd_dout(rd_dout), .rd_read(rd_read_b),
        .wr_full(wr_full), .wr_write(wr_write_b), .wr_din(wr_din_b),
        .wr_tag(wr_tag_b), .sat_count(sat_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-half-up, floor division by 2^11, then clamp to the output range.
    function automatic longint descale(input logic [31:0] x, input int sgn, input int ow,
                                       output bit clipped);
        longint v, hi, lo;
        v  = sgn ? longint'($signed(x)) : longint'(x);
        v  = (v + 1024) >>> 11;
        hi = sgn ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        lo = sgn ? -(longint'(1) << (ow - 1)) : 0;
        clipped = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return v & ((longint'(1) << ow) - 1);
    endfunction

    int     cfg_arb [2] = '{1, 0};
    int     cfg_sgn [2] = '{1, 0};
    int     cfg_ow  [2] = '{16, 8};
    bit     m_valid [2];
    longint m_data  [2];
    int     m_tag   [2];
    int     m_last  [2];
    int     m_sat   [2];

    always @(negedge clk) begin
        bit          exp_write, can, found, clipped;
        int          win;
        logic [1:0]  exp_rd;
        logic [63:0] a_rd, a_wr, a_din, a_tag, a_sat;
        longint      val;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_valid[d] = 1'b0;
                m_data[d]  = 0;
                m_tag[d]   = 0;
                m_last[d]  = 1;
                m_sat[d]   = 0;
            end
            exp_write = m_valid[d] && !wr_full;
            can       = rst_n && en && (!m_valid[d] || !wr_full) && (rd_empty != 2'b11);
            win       = 0;
            found     = 1'b0;
            if (cfg_arb[d] == 0) begin
                if (!rd_empty[1]) win = 1;
                else win = 0;
            end else begin
                for (int k = 1; k <= 2; k++) begin
                    if (!found && !rd_empty[(m_last[d] + k) % 2]) begin
                        found = 1'b1;
                        win   = (m_last[d] + k) % 2;
                    end
                end
            end
            exp_rd = can ? (2'b01 << win) : 2'b00;
            a_rd   = (d == 0) ? 64'(rd_read_a)  : 64'(rd_read_b);
            a_wr   = (d == 0) ? 64'(wr_write_a) : 64'(wr_write_b);
            a_din  = (d == 0) ? 64'(wr_din_a)   : 64'(wr_din_b);
            a_tag  = (d == 0) ? 64'(wr_tag_a)   : 64'(wr_tag_b);
            a_sat  = (d == 0) ? 64'(sat_a)      : 64'(sat_b);
            chk(d == 0 ? "model.a.rd_read"   : "model.b.rd_read",   a_rd,  64'(exp_rd));
            chk(d == 0 ? "model.a.wr_write"  : "model.b.wr_write",  a_wr,  64'(exp_write));
            chk(d == 0 ? "model.a.wr_din"    : "model.b.wr_din",    a_din, 64'(m_data[d]));
            chk(d == 0 ? "model.a.wr_tag"    : "model.b.wr_tag",    a_tag, 64'(m_tag[d]));
            chk(d == 0 ? "model.a.sat_count" : "model.b.sat_count", a_sat, 64'(m_sat[d]));
            if (rst_n) begin
                val = descale(rd_dout[win*32 +: 32], cfg_sgn[d], cfg_ow[d], clipped);
                if (clr_stats) m_sat[d] = 0;
                else if (can && clipped && m_sat[d] < 65535) m_sat[d] = m_sat[d] + 1;
                if (can) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = val;
                    m_tag[d]   = win;
                    if (cfg_arb[d] != 0) m_last[d] = win;
                end else if (exp_write) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One sample from channel ch, then idle; ends at the negedge after the load edge.
    task automatic load_one(input int ch, input logic [31:0] x);
        cyc();
        rd_empty = ~(2'b01 << ch);
        rd_dout  = {x, x};
        @(negedge clk);
        chk("load.rd_read", 64'(rd_read_a), 64'(2'b01 << ch));
        cyc();
        rd_empty = 2'b11;
        @(negedge clk);
        chk("load.wr_write", 64'(wr_write_a), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'h000003FF + 32'($urandom_range(0, 2)) * 32'h400;
            3:       return 32'($urandom_range(0, 200000)) - 32'd100000;
            4:       return 32'($urandom_range(0, 600000));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] r_in  [4] = '{32'h00000400, 32'h000003FF, 32'hFFFFFC00, 32'hFFFFFBFF};
    logic [15:0] r_exp [4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        clr_stats = 1'b0;
        wr_full   = 1'b0;
        rd_empty  = 2'b00;
        rd_dout   = '0;

        // Reset state, with inputs non-empty so the read gating is exercised.
        @(negedge clk);
        chk("reset.rd_read",   64'(rd_read_a),  64'd0);
        chk("reset.wr_write",  64'(wr_write_a), 64'd0);
        chk("reset.wr_din",    64'(wr_din_a),   64'd0);
        chk("reset.wr_tag",    64'(wr_tag_a),   64'd0);
        chk("reset.sat_count", 64'(sat_a),      64'd0);

        // Arbitration with both channels non-empty.
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("arb.a.rd_read", 64'(rd_read_a), (k % 2 == 1) ? 64'd2 : 64'd1);
            chk("arb.b.rd_read", 64'(rd_read_b), 64'd2);
            if (k > 0) begin
                chk("arb.a.wr_tag", 64'(wr_tag_a), 64'((k - 1) % 2));
                chk("arb.b.wr_tag", 64'(wr_tag_b), 64'd1);
            end
            cyc();
        end
        rd_empty = 2'b11;

        // Rounding around the half-LSB boundary.
        for (int i = 0; i < 4; i++) begin
            load_one(0, r_in[i]);
            chk("round.wr_din", 64'(wr_din_a), 64'(r_exp[i]));
        end
        chk("round.sat_count", 64'(sat_a), 64'd0);

        // Saturation at both rails, then statistic clear.
        load_one(0, 32'h7FFFFFFF);
        chk("sat.wr_din_pos", 64'(wr_din_a), 64'h7FFF);
        load_one(0, 32'h80000000);
        chk("sat.wr_din_neg", 64'(wr_din_a), 64'h8000);
        chk("sat.sat_count", 64'(sat_a), 64'd2);
        cyc();
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        @(negedge clk);
        chk("clr.sat_count", 64'(sat_a), 64'd0);

        // Unsigned 8-bit instance.
        load_one(0, 32'h0007FC00);
        chk("uns.wr_din_clip", 64'(wr_din_b), 64'hFF);
        chk("uns.sat_count1", 64'(sat_b), 64'd1);
        load_one(0, 32'h00000C00);
        chk("uns.wr_din", 64'(wr_din_b), 64'h02);
        chk("uns.sat_count2", 64'(sat_b), 64'd1);

        // Backpressure: output held, no reads, then write and read together.
        cyc();
        rd_empty = 2'b10;
        rd_dout  = {32'h0, 32'h00001800};
        cyc();
        rd_empty = 2'b00;
        wr_full  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.wr_write", 64'(wr_write_a), 64'd0);
            chk("bp.rd_read",  64'(rd_read_a),  64'd0);
            chk("bp.wr_din",   64'(wr_din_a),   64'd3);
            cyc();
        end
        wr_full = 1'b0;
        @(negedge clk);
        chk("bp.release_write", 64'(wr_write_a), 64'd1);
        chk("bp.release_read",  64'(rd_read_a),  64'd2);
        cyc();
        rd_empty = 2'b11;

        // Asynchronous reset with a pending, clipped sample stuck behind wr_full.
        cyc();
        rd_empty = 2'b10;
        rd_dout  = {32'h0, 32'h7FFFFFFF};
        cyc();
        rd_empty = 2'b00;
        wr_full  = 1'b1;
        @(negedge clk);
        chk("areset.pre_sat", 64'(sat_a), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        wr_full = 1'b0;
        #1;
        chk("areset.wr_write",  64'(wr_write_a), 64'd0);
        chk("areset.rd_read",   64'(rd_read_a),  64'd0);
        chk("areset.sat_count", 64'(sat_a),      64'd0);
        chk("areset.b_write",   64'(wr_write_b), 64'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset.first_grant", 64'(rd_read_a), 64'd1);
        cyc();
        rd_empty = 2'b11;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cyc();
            en        = ($urandom_range(0, 3) != 0);
            wr_full   = ($urandom_range(0, 2) == 0);
            rd_empty  = 2'($urandom);
            clr_stats = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < 2; c++) begin
                rd_dout[c*32 +: 32] = pick();
            end
        end
        cyc();
        en        = 1'b0;
        wr_full   = 1'b0;
        rd_empty  = 2'b11;
        clr_stats = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
